// File: rtl/ff_bank_pkg.sv
// Shared definitions for the ff_bank multi-mode register bank.
// Mode encoding and width constant used by the top and its next-state logic.
package ff_bank_pkg;

    localparam int MODE_W = 3;

    typedef enum logic [MODE_W-1:0] {
        M_HOLD = 3'd0,
        M_D    = 3'd1,
        M_T    = 3'd2,
        M_JK   = 3'd3,
        M_SR   = 3'd4,
        M_SHL  = 3'd5,
        M_SHR  = 3'd6,
        M_ROL  = 3'd7
    } mode_e;

    // True for the modes that move a bit out through sout.
    function automatic logic is_shift_mode(input mode_e m);
        return (m == M_SHL) || (m == M_SHR) || (m == M_ROL);
    endfunction

endpackage

// File: rtl/ff_bank_next.sv
// Combinational next-state logic for ff_bank.
// Produces the candidate register value, the shifted-out bit and the SR-conflict flag.
module ff_bank_next
    import ff_bank_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  mode_e            mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sin,
    output logic [WIDTH-1:0] q_next,
    output logic             sout_next,
    output logic             shift_op,
    output logic             conflict
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        q_next    = q;
        sout_next = 1'b0;
        shift_op  = is_shift_mode(mode);
        conflict  = 1'b0;

        case (mode)
            M_HOLD: q_next = q;
            M_D:    q_next = a;
            M_T:    q_next = q ^ a;
            M_JK: begin
                // J sets, K clears, both toggles, neither holds.
                q_next = (a & ~b & ~q) | (a & ~q) | (~b & q);
            end
            M_SR: begin
                // Conflicting bits (S=R=1) keep their old value.
                q_next   = (a & ~b) | (q & ~(~a & b));
                conflict = |(a & b);
            end
            M_SHL: begin
                q_next    = {q[WIDTH-2:0], sin};
                sout_next = q[WIDTH-1];
            end
            M_SHR: begin
                q_next    = {sin, q[WIDTH-1:1]};
                sout_next = q[0];
            end
            M_ROL: begin
                q_next    = {q[WIDTH-2:0], q[WIDTH-1]};
                sout_next = q[WIDTH-1];
            end
            default: q_next = q;
        endcase
    end

endmodule

// File: rtl/ff_bank.sv
// Parametrised multi-mode register bank: D/T/JK/SR/shift/rotate behaviour per cycle,
// with registered serial-out, change flag and SR-conflict flag.
module ff_bank
    import ff_bank_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [MODE_W-1:0] mode,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic              sin,
    output logic [WIDTH-1:0]  q,
    output logic [WIDTH-1:0]  qn,
    output logic              sout,
    output logic              changed,
    output logic              sr_err
);

    logic [WIDTH-1:0] q_q, q_d;
    logic             sout_q, sout_d;
    logic             changed_q, changed_d;
    logic             sr_err_q, sr_err_d;

    logic [WIDTH-1:0] q_next;
    logic             sout_next;
    logic             shift_op;
    logic             conflict;
    mode_e            mode_sel;

    assign mode_sel = mode_e'(mode);

    ff_bank_next #(
        .WIDTH (WIDTH)
    ) u_next (
        .q         (q_q),
        .mode      (mode_sel),
        .a         (a),
        .b         (b),
        .sin       (sin),
        .q_next    (q_next),
        .sout_next (sout_next),
        .shift_op  (shift_op),
        .conflict  (conflict)
    );

    always_comb begin
        q_d       = q_q;
        sout_d    = sout_q;
        changed_d = 1'b0;
        sr_err_d  = 1'b0;
        if (en) begin
            q_d       = q_next;
            changed_d = (q_next != q_q);
            sr_err_d  = (mode_sel == M_SR) && conflict;
            if (shift_op) begin
                sout_d = sout_next;
            end
        end
    end

    // NOTE: reset is synchronous, so it lives inside the clocked block with no async path.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            q_q       <= RST_VAL;
            sout_q    <= 1'b0;
            changed_q <= 1'b0;
            sr_err_q  <= 1'b0;
        end else begin
            q_q       <= q_d;
            sout_q    <= sout_d;
            changed_q <= changed_d;
            sr_err_q  <= sr_err_d;
        end
    end

    assign q       = q_q;
    assign qn      = ~q_q;
    assign sout    = sout_q;
    assign changed = changed_q;
    assign sr_err  = sr_err_q;

endmodule
